// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path. This package
//                holds the frame constants, the receiver state encoding and
//                the even-parity helper.
//  Contents    : UART_* constants, uart_rx_state_t, uart_parity()
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int   UART_FRAME_BITS  = 11;    // start + 8 data + parity + stop
   localparam int   UART_DATA_BITS   = 8;
   localparam logic UART_START_LEVEL = 1'b1;
   localparam logic UART_STOP_LEVEL  = 1'b1;
   localparam logic UART_IDLE_LEVEL  = 1'b0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_rx_state_t;

   // XOR reduction of a data byte. A frame has good even parity when this
   // value XOR the received parity bit is 0.
   function automatic logic uart_parity(input logic [7:0] data_byte);
      return ^data_byte;
   endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame
//  Description : Single-frame UART deserializer. It synchronizes rx, detects
//                the rising start edge and samples each bit at mid-bit. It
//                checks parity and the stop level, then reports the result as
//                single-cycle strobes that are valid during the stop-bit
//                sample cycle.
//  Ports       : clk_baud    in   oversampled bit clock
//                rst         in   asynchronous active-high reset
//                rx          in   raw serial line (idle 0)
//                data        out  received byte (meaningful with frame_end)
//                data_valid  out  strobe: good byte (parity and stop ok)
//                parity_err  out  strobe: parity mismatch
//                frame_err   out  strobe: stop bit 0 or false start
//                frame_end   out  strobe: a complete frame was sampled
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_baud,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       frame_end
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic           rx_meta;
   logic           rx_sync;
   logic           rx_prev;
   uart_rx_state_t state;
   uart_rx_state_t state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [2:0]     bit_cnt;
   logic [2:0]     bit_cnt_next;
   logic [7:0]     shreg;
   logic [7:0]     shreg_next;
   logic           par_bit;
   logic           par_bit_next;
   logic           stop_ok;
   logic           par_bad;

   // ---------------------------------------------------------------------
   // Synchronizer plus one delayed copy for start-edge detection
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_baud or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b0;
         rx_sync <= 1'b0;
         rx_prev <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_baud or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_cnt <= bit_cnt_next;
         shreg   <= shreg_next;
         par_bit <= par_bit_next;
      end
   end

   assign stop_ok = (rx_sync == UART_STOP_LEVEL);
   assign par_bad = uart_parity(shreg) ^ par_bit;
   assign data    = shreg;

   // ---------------------------------------------------------------------
   // Next-state and strobe logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      cnt_next     = cnt + CNT_W'(1);
      bit_cnt_next = bit_cnt;
      shreg_next   = shreg;
      par_bit_next = par_bit;
      data_valid   = 1'b0;
      parity_err   = 1'b0;
      frame_err    = 1'b0;
      frame_end    = 1'b0;

      case (state)
         IDLE: begin
            cnt_next = '0;
            if (rx_sync && !rx_prev) begin
               state_next = START;
            end
         end

         START: begin
            if (cnt == MID_CNT) begin
               // The counter is restarted here, so every later sample
               // lands one full bit time later at LAST_CNT (mid-bit).
               cnt_next     = '0;
               bit_cnt_next = '0;
               if (rx_sync == UART_START_LEVEL) begin
                  state_next = DATA;
               end else begin
                  frame_err  = 1'b1;
                  state_next = IDLE;
               end
            end
         end

         DATA: begin
            if (cnt == LAST_CNT) begin
               cnt_next     = '0;
               shreg_next   = {rx_sync, shreg[7:1]};   // LSB arrives first
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == LAST_BIT) begin
                  state_next = PARITY;
               end
            end
         end

         PARITY: begin
            if (cnt == LAST_CNT) begin
               cnt_next     = '0;
               par_bit_next = rx_sync;
               state_next   = STOP;
            end
         end

         STOP: begin
            if (cnt == LAST_CNT) begin
               cnt_next   = '0;
               frame_end  = 1'b1;
               frame_err  = !stop_ok;
               parity_err = par_bad;
               data_valid = stop_ok && !par_bad;
               state_next = WAIT_IDLE;
            end
         end

         WAIT_IDLE: begin
            cnt_next = '0;
            if (rx_sync == UART_IDLE_LEVEL) begin
               state_next = IDLE;
            end
         end

         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

endmodule : uart_rx_frame
`default_nettype wire

// File: rtl/uart_decode.sv
`default_nettype none
// ============================================================================
//  Module      : uart_decode
//  Description : UART receive framing stage. It decodes 11-bit frames through
//                uart_rx_frame and assembles good bytes, most-significant
//                first, into a PACKET_SIZE-bit packet. The packet is then
//                offered to the consumer with a valid/ack handshake.
//  Ports       : clk_baud      in   oversampled bit clock (sole clock)
//                rst           in   asynchronous active-high reset
//                rx            in   serial line, idle 0
//                sys_packet    out  assembled packet, stable while valid
//                packet_valid  out  packet available until acknowledged
//                packet_ack    in   consumer accepts packet
//                byte_out      out  last good data byte
//                byte_valid    out  one-cycle pulse per good byte
//                parity_err    out  one-cycle pulse on parity mismatch
//                frame_err     out  one-cycle pulse on bad stop/false start
//                overrun       out  sticky: packet dropped while one pending
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_decode
   import uart_pkg::*;
#(
   parameter int PACKET_SIZE = 32,
   parameter int OVERSAMPLE  = 16
) (
   input  logic                   clk_baud,
   input  logic                   rst,
   input  logic                   rx,
   output logic [PACKET_SIZE-1:0] sys_packet,
   output logic                   packet_valid,
   input  logic                   packet_ack,
   output logic [7:0]             byte_out,
   output logic                   byte_valid,
   output logic                   parity_err,
   output logic                   frame_err,
   output logic                   overrun
);

   localparam int NUM_BYTES = PACKET_SIZE / 8;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   logic [7:0]             rx_data;
   logic                   rx_valid;
   logic                   rx_perr;
   logic                   rx_ferr;
   logic                   rx_end;
   logic [IDX_W-1:0]       idx;
   logic [PACKET_SIZE-1:0] asm_buf;
   logic [PACKET_SIZE-1:0] asm_next;
   logic                   last_byte;
   logic                   can_publish;

   uart_rx_frame #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_rx_frame (
      .clk_baud   (clk_baud),
      .rst        (rst),
      .rx         (rx),
      .data       (rx_data),
      .data_valid (rx_valid),
      .parity_err (rx_perr),
      .frame_err  (rx_ferr),
      .frame_end  (rx_end)
   );

   // Assembly buffer with the incoming byte merged into the slot selected
   // by idx; byte 0 occupies the most-significant position.
   always_comb begin
      asm_next = asm_buf;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (idx == IDX_W'(b)) begin
            asm_next[PACKET_SIZE-8-8*b +: 8] = rx_data;
         end
      end
   end

   assign last_byte   = (idx == LAST_IDX);
   // A finished packet may replace sys_packet only if the slot is free or
   // is being acknowledged in this very cycle.
   assign can_publish = !packet_valid || packet_ack;

   always_ff @(posedge clk_baud or posedge rst) begin
      if (rst) begin
         sys_packet   <= '0;
         packet_valid <= 1'b0;
         byte_out     <= '0;
         byte_valid   <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
         idx          <= '0;
         asm_buf      <= '0;
      end else begin
         byte_valid <= rx_valid;
         parity_err <= rx_perr;
         frame_err  <= rx_ferr;

         if (packet_valid && packet_ack) begin
            packet_valid <= 1'b0;
         end

         // A false start raises frame_err without frame_end, so it leaves
         // the byte index alone; a bad complete frame abandons the packet.
         if (rx_end) begin
            if (rx_valid) begin
               byte_out <= rx_data;
               asm_buf  <= asm_next;
               if (last_byte) begin
                  idx <= '0;
                  if (can_publish) begin
                     sys_packet   <= asm_next;
                     packet_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end else begin
               idx <= '0;
            end
         end
      end
   end

endmodule : uart_decode
`default_nettype wire

// File: tb/tb_uart_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_decode
//  Description : Directed self-checking bench for uart_decode. A monitor logs
//                byte_valid events and error pulses; each scenario task
//                drives frames and compares the log against hand-computed
//                values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_decode;

   localparam int PS = 32;
   localparam int OS = 16;

   logic          clk_baud = 1'b0;
   logic          rst;
   logic          rx;
   logic [PS-1:0] sys_packet;
   logic          packet_valid;
   logic          packet_ack;
   logic [7:0]    byte_out;
   logic          byte_valid;
   logic          parity_err;
   logic          frame_err;
   logic          overrun;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic          pv;
      logic [PS-1:0] pkt;
      logic [7:0]    b;
   } ev_t;

   ev_t evq[$];
   int  perr_n = 0;
   int  ferr_n = 0;

   uart_decode #(
      .PACKET_SIZE (PS),
      .OVERSAMPLE  (OS)
   ) dut (
      .clk_baud     (clk_baud),
      .rst          (rst),
      .rx           (rx),
      .sys_packet   (sys_packet),
      .packet_valid (packet_valid),
      .packet_ack   (packet_ack),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .parity_err   (parity_err),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   always #5 clk_baud = ~clk_baud;

   // Event logger: one entry per byte_valid cycle, one count per error cycle
   always @(negedge clk_baud) begin
      if (!rst) begin
         if (byte_valid) evq.push_back('{pv: packet_valid, pkt: sys_packet, b: byte_out});
         if (parity_err) perr_n++;
         if (frame_err)  ferr_n++;
      end
   end

   function automatic ev_t ev_at(input int i);
      if (i < evq.size()) return evq[i];
      return '0;
   endfunction

   task automatic clear_log();
      evq.delete();
      perr_n = 0;
      ferr_n = 0;
   endtask

   // Drives the first nbits bits of a frame (start first), then two idle
   // bit times once the whole frame is sent. Entered and left at a negedge.
   task automatic send_frame(input logic [7:0] b, input logic par,
                             input logic stp, input int nbits);
      logic [10:0] bits;
      bits = {stp, par, b, 1'b1};
      for (int i = 0; i < nbits; i++) begin
         rx = bits[i];
         repeat (OS) @(negedge clk_baud);
      end
      if (nbits == 11) begin
         rx = 1'b0;
         repeat (2 * OS) @(negedge clk_baud);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, ^b, 1'b1, 11);
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b0; packet_ack = 1'b0;
      repeat (3) @(negedge clk_baud);
      n_checks++;
      if ({sys_packet, packet_valid, overrun} !== '0)
         $display("FAIL reset_pkt: got %h/%b/%b want 0/0/0", sys_packet, packet_valid, overrun);
      else n_pass++;
      n_checks++;
      if ({byte_out, byte_valid, parity_err, frame_err} !== '0)
         $display("FAIL reset_byte: got %h/%b/%b/%b want 0", byte_out, byte_valid, parity_err, frame_err);
      else n_pass++;
      rst = 1'b0;
      repeat (OS) @(negedge clk_baud);
   endtask

   task automatic test_packet();
      logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      packet_ack = 1'b1;
      clear_log();
      send_frame(8'hDE, 1'b0, 1'b1, 11);
      send_frame(8'hAD, 1'b1, 1'b1, 11);
      send_frame(8'hBE, 1'b0, 1'b1, 11);
      send_frame(8'hEF, 1'b1, 1'b1, 11);
      n_checks++;
      if (evq.size() != 4) $display("FAIL pkt_nbytes: got %0d want 4", evq.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ev_at(i).b !== exp_b[i])
            $display("FAIL pkt_byte%0d: got %h want %h", i, ev_at(i).b, exp_b[i]);
         else n_pass++;
      end
      n_checks++;
      if (ev_at(2).pv !== 1'b0 || ev_at(3).pv !== 1'b1)
         $display("FAIL pkt_valid_timing: got %b%b want 01", ev_at(2).pv, ev_at(3).pv);
      else n_pass++;
      n_checks++;
      if (ev_at(3).pkt !== 32'hDEADBEEF)
         $display("FAIL pkt_data: got %h want deadbeef", ev_at(3).pkt);
      else n_pass++;
      n_checks++;
      if (perr_n != 0 || ferr_n != 0 || overrun !== 1'b0)
         $display("FAIL pkt_no_err: got perr=%0d ferr=%0d ovr=%b want 0 0 0", perr_n, ferr_n, overrun);
      else n_pass++;
      n_checks++;
      if (packet_valid !== 1'b0)
         $display("FAIL pkt_acked: got %b want 0", packet_valid);
      else n_pass++;
   endtask

   task automatic test_parity_err();
      packet_ack = 1'b1;
      clear_log();
      send_byte(8'h99);
      send_frame(8'hA5, 1'b1, 1'b1, 11);
      n_checks++;
      if (perr_n != 1 || ferr_n != 0 || evq.size() != 1)
         $display("FAIL par_err: got perr=%0d ferr=%0d bytes=%0d want 1 0 1", perr_n, ferr_n, evq.size());
      else n_pass++;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      n_checks++;
      if (ev_at(4).pv !== 1'b1 || ev_at(4).pkt !== 32'h11223344)
         $display("FAIL par_recover: got pv=%b pkt=%h want 1 11223344", ev_at(4).pv, ev_at(4).pkt);
      else n_pass++;
   endtask

   task automatic test_frame_err();
      packet_ack = 1'b1;
      clear_log();
      send_byte(8'h77);
      send_frame(8'h3C, 1'b0, 1'b0, 11);
      n_checks++;
      if (ferr_n != 1 || perr_n != 0 || evq.size() != 1)
         $display("FAIL stop_err: got ferr=%0d perr=%0d bytes=%0d want 1 0 1", ferr_n, perr_n, evq.size());
      else n_pass++;
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
      n_checks++;
      if (ev_at(4).pv !== 1'b1 || ev_at(4).pkt !== 32'hA1B2C3D4)
         $display("FAIL stop_recover: got pv=%b pkt=%h want 1 a1b2c3d4", ev_at(4).pv, ev_at(4).pkt);
      else n_pass++;
   endtask

   task automatic test_glitch();
      packet_ack = 1'b1;
      clear_log();
      rx = 1'b1;
      repeat (OS / 4) @(negedge clk_baud);
      rx = 1'b0;
      repeat (3 * OS) @(negedge clk_baud);
      n_checks++;
      if (ferr_n != 1 || perr_n != 0 || evq.size() != 0)
         $display("FAIL glitch: got ferr=%0d perr=%0d bytes=%0d want 1 0 0", ferr_n, perr_n, evq.size());
      else n_pass++;
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      n_checks++;
      if (evq.size() != 4 || ev_at(3).pkt !== 32'h12345678 || ev_at(3).pv !== 1'b1)
         $display("FAIL glitch_recover: got n=%0d pkt=%h want 4 12345678", evq.size(), ev_at(3).pkt);
      else n_pass++;
   endtask

   task automatic test_overrun();
      packet_ack = 1'b0;
      clear_log();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      n_checks++;
      if (packet_valid !== 1'b1 || sys_packet !== 32'h01020304 || overrun !== 1'b0)
         $display("FAIL ovr_first: got pv=%b pkt=%h ovr=%b want 1 01020304 0", packet_valid, sys_packet, overrun);
      else n_pass++;
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      n_checks++;
      if (packet_valid !== 1'b1 || sys_packet !== 32'h01020304 || overrun !== 1'b1)
         $display("FAIL ovr_second: got pv=%b pkt=%h ovr=%b want 1 01020304 1", packet_valid, sys_packet, overrun);
      else n_pass++;
      n_checks++;
      if (evq.size() != 8 || ev_at(7).b !== 8'h08)
         $display("FAIL ovr_bytes: got n=%0d last=%h want 8 08", evq.size(), ev_at(7).b);
      else n_pass++;
      packet_ack = 1'b1;
      @(negedge clk_baud);
      packet_ack = 1'b0;
      n_checks++;
      if (packet_valid !== 1'b0 || overrun !== 1'b1)
         $display("FAIL ovr_ack: got pv=%b ovr=%b want 0 1", packet_valid, overrun);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      packet_ack = 1'b1;
      clear_log();
      send_byte(8'h5A);
      send_frame(8'hC3, ^8'hC3, 1'b1, 4);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({sys_packet, packet_valid, byte_out, byte_valid, parity_err, frame_err, overrun} !== '0)
         $display("FAIL rst_mid: got pkt=%h pv=%b byte=%h ovr=%b want all 0", sys_packet, packet_valid, byte_out, overrun);
      else n_pass++;
      rx = 1'b0;
      repeat (3) @(negedge clk_baud);
      rst = 1'b0;
      repeat (2 * OS) @(negedge clk_baud);
      clear_log();
      send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
      n_checks++;
      if (evq.size() != 4 || ev_at(3).pv !== 1'b1 || ev_at(3).pkt !== 32'hCAFEF00D)
         $display("FAIL rst_recover: got n=%0d pkt=%h want 4 cafef00d", evq.size(), ev_at(3).pkt);
      else n_pass++;
      n_checks++;
      if (perr_n != 0 || ferr_n != 0 || overrun !== 1'b0)
         $display("FAIL rst_recover_err: got perr=%0d ferr=%0d ovr=%b want 0 0 0", perr_n, ferr_n, overrun);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_packet();
      test_parity_err();
      test_frame_err();
      test_glitch();
      test_overrun();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_uart_decode
`default_nettype wire

// File: doc/uart_decode.md
Name: uart_decode

Overview:
- Receive-side counterpart of the BPSK receiver's UART framing stage. It deserializes 11-bit UART frames from a single serial line, checks parity and stop bits, and reassembles consecutive bytes into a PACKET_SIZE-bit system packet.
- Frame order on the line is LSB first: open (start), data[0..7], parity, close (stop).
- Bytes arrive most-significant byte of the system packet first.
- Sits between the line front-end and the packet consumer.

Parameters:
- PACKET_SIZE, 32, system packet width in bits; must be a multiple of 8 and at least 8.
- OVERSAMPLE, 16, clk_baud cycles per bit time; even, at least 4.

Ports:
- clk_baud  in  1  sole clock; OVERSAMPLE × bit rate.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, asynchronous to clk_baud; idle level 0.
- sys_packet  out  PACKET_SIZE  assembled packet; stable while packet_valid=1.
- packet_valid  out  1  packet available; held until packet_ack.
- packet_ack  in  1  consumer accepts packet; ignored when packet_valid=0.
- byte_out  out  8  last good data byte.
- byte_valid  out  1  one-cycle pulse per good byte.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0, or false start.
- overrun  out  1  sticky; packet completed while packet_valid=1; cleared by rst only.

Behaviour:
- Reset (async assert; deassert is synchronous to clk_baud): all outputs 0, byte index 0, state IDLE, synchronizer flops 0.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Frame levels: start=1, stop=1, idle=0. Parity is even: data[7:0] XOR parity must equal 0.
- Consecutive frames need at least one idle bit time between them. Start detection is a synchronized 0→1 edge.
- State IDLE: on rising edge, clear the sample counter and go to START.
- State START: at count OVERSAMPLE/2-1 (mid-bit), sample. If 1, go to DATA with the counter reset. If 0, pulse frame_err and return to IDLE; no byte-index change.
- State DATA: sample every OVERSAMPLE cycles at mid-bit. Shift each sample into bit position 0..7 (LSB first). After 8 samples go to PARITY.
- State PARITY: sample one bit, then go to STOP.
- State STOP: sample one bit, then act in the next cycle:
  - stop=0: pulse frame_err.
  - parity mismatch: pulse parity_err.
  - both stop=0 and parity mismatch: assert both.
  - any error: discard the byte and reset the byte index to 0, abandoning the partial packet.
  - no error: pulse byte_valid with byte_out updated, and write the byte to sys_packet[PACKET_SIZE-8-8*idx +: 8]. Then idx increments, wrapping to 0 after PACKET_SIZE/8 bytes.
- After STOP, go to WAIT_IDLE; return to IDLE when synchronized rx=0.
- Packet completion:
  - On the last good byte, set packet_valid in the same cycle as that byte's byte_valid.
  - The assembly buffer is separate from sys_packet. The completed packet is copied to sys_packet only if packet_valid=0, or if packet_ack=1 in that same cycle.
  - Otherwise the new packet is dropped and overrun is set.
- Handshake: packet_valid=1 and packet_ack=1 clears packet_valid on the next edge, unless a new packet completes in the same cycle; then packet_valid stays 1 with the new data.
- Latency: byte_valid rises 1 clk_baud cycle after the stop-bit mid-sample, which is 2 synchronizer cycles plus roughly 10.5 bit times after the start edge.
- Counters: sample counter is $clog2(OVERSAMPLE) bits; byte index is $clog2(PACKET_SIZE/8) bits, minimum 1.
- rst mid-frame or mid-packet: immediate return to reset state; the partial byte and packet are lost with no error pulse.

Decomposition:
- Package uart_pkg:
  - constants UART_FRAME_BITS=11, UART_DATA_BITS=8, UART_START_LEVEL=1, UART_STOP_LEVEL=1, UART_IDLE_LEVEL=0;
  - state enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - function uart_parity(byte) returning XOR reduction.
- Sub-module uart_rx_frame owns the synchronizer, FSM and bit sampling. It outputs a byte with a valid, parity_err and frame_err. uart_decode instantiates it and adds packet assembly, the handshake and overrun.

Test Plan:
- Packet 0xDEADBEEF: frames DE/p0, AD/p1, BE/p0, EF/p1, 2 idle bits apart, packet_ack tied 1 → 4 byte_valid pulses with byte_out DE, AD, BE, EF. packet_valid on the 4th pulse with sys_packet=0xDEADBEEF; no error pulses.
- Byte 0xA5 sent with parity=1 as the 2nd byte of a packet → parity_err pulse, no byte_valid. Then 4 good bytes 11, 22, 33, 44 → sys_packet=0x11223344.
- Frame 0x3C with stop=0 → single frame_err pulse. The following good frame lands in the top byte (idx reset).
- 0→1 glitch of OVERSAMPLE/4 cycles on idle rx → frame_err pulse, state back to IDLE. A following valid packet decodes correctly.
- Two packets 0x01020304 then 0x05060708, packet_ack held 0 → packet_valid=1 with sys_packet=0x01020304 and overrun=1 after the second. Ack pulse → packet_valid=0 next cycle.
- rst asserted mid-DATA of byte 2 → all outputs 0 immediately. A subsequent full 0xCAFEF00D packet decodes correctly.
